// File: rtl/piso_bit_serializer.sv
// ---------------------------------------------------------------------------
// piso_bit_serializer
//
// Parallel-in / serial-out stage that feeds the serial sequence detector.
// WIDTH-bit words arrive over a valid/ready handshake and leave one bit per
// clock on `data`. A one-word holding buffer lets a second word be accepted
// while the current one is still shifting, so consecutive frames stream
// with no idle cycle between them.
//
// Parameters
//   WIDTH      bits per input word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT   level driven on `data` while no frame is being shifted
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   in_data      parallel word to serialize
//   in_valid     in_data is valid
//   in_ready     block can accept a word this cycle (combinational)
//   data         serial bit stream (registered)
//   data_valid   data carries a frame bit this cycle (registered)
//   frame_start  pulse on the first bit of each word (registered)
//   frame_done   pulse on the last bit of each word (registered)
//   busy         shifter or holding buffer occupied (registered)
// ---------------------------------------------------------------------------
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             data_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic [CW-1:0]    cnt_inc;

  // Bit that leaves the word first, according to the shift direction.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its first-out bit removed, so the next bit to send moves into
  // the position first_bit() reads.
  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The holding buffer is the only thing that can refuse a word; reset also
  // blocks transfers so a word offered during reset is never consumed.
  assign in_ready = ~hold_full_q & ~rst;
  assign accept   = in_valid & in_ready;

  // The bit on `data` right now is the last one of its frame.
  assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
  assign cnt_inc  = cnt_q + CW'(1);

  // Next-state and next-output logic. The shift register holds the bits not
  // yet presented; `data_q` holds the bit being presented this cycle, so each
  // edge either advances within the frame or loads a fresh word whose first
  // bit appears straight away.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    data_d        = IDLE_BIT;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    load          = 1'b0;
    load_word     = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load      = 1'b1;
          load_word = in_data;
        end
      end

      S_SHIFT: begin
        if (last_bit) begin
          // Next word source: buffered word first, then a word arriving on
          // this very edge (bypassing the buffer), otherwise fall idle.
          if (hold_full_q) begin
            load        = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            load      = 1'b1;
            load_word = in_data;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d        = cnt_inc;
          data_d       = first_bit(shift_q);
          shift_d      = drop_bit(shift_q);
          data_valid_d = 1'b1;
          frame_done_d = (cnt_inc == LAST_CNT);
          if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      state_d       = S_SHIFT;
      cnt_d         = '0;
      data_d        = first_bit(load_word);
      shift_d       = drop_bit(load_word);
      data_valid_d  = 1'b1;
      frame_start_d = 1'b1;
    end

    busy_d = (state_d == S_SHIFT) | hold_full_d;
  end

  // State and output registers. Reset drops any frame in flight together
  // with the buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      data_q        <= IDLE_BIT;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule
